// File: rtl/spi_rx_slave_if.sv
// spi_rx_slave_if: pin and word-level bundle for the SPI mode-0 receiver.
//   sclk, cs_n, mosi, dc : SPI pins driven by the bus controller
//   miso                 : serial response from the peripheral
//   tx_data / tx_taken   : response word supplied to the peripheral / load strobe
//   rx_data / rx_dc      : last completed received word and its D/C tag
//   rx_valid             : strobe, rx_data/rx_dc updated
//   frame_err            : strobe, chip select released mid-word
// The slave modport is the peripheral (spi_rx_slave); master is the controller side.
`timescale 1ns/1ps
interface spi_rx_slave_if #(
  parameter int DW = 8
);
  logic          sclk;
  logic          cs_n;
  logic          mosi;
  logic          dc;
  logic          miso;
  logic [DW-1:0] tx_data;
  logic          tx_taken;
  logic [DW-1:0] rx_data;
  logic          rx_dc;
  logic          rx_valid;
  logic          frame_err;

  modport slave (
    input  sclk, cs_n, mosi, dc, tx_data,
    output miso, tx_taken, rx_data, rx_dc, rx_valid, frame_err
  );

  modport master (
    output sclk, cs_n, mosi, dc, tx_data,
    input  miso, tx_taken, rx_data, rx_dc, rx_valid, frame_err
  );
endinterface

// File: rtl/spi_rx_slave.sv
// spi_rx_slave: SPI mode-0 peripheral-side receiver with a response shifter.
// Oversamples sclk/cs_n/mosi/dc on clk, deserialises mosi MSB first into DW-bit
// words tagged with the D/C bit, and serialises tx_data onto miso MSB first.
// Ports:
//   clk  : system clock, at least 8x the sclk rate
//   rst  : asynchronous active-high reset
//   bus  : spi_rx_slave_if.slave (pins, tx_data/tx_taken, rx_* and frame_err)
`timescale 1ns/1ps
module spi_rx_slave #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  spi_rx_slave_if.slave bus
);

  localparam int            CW       = $clog2(DW + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  // Synchroniser chains: bit 0 = first stage, bit 1 = s2, bit 2 = s3 (edge reference).
  // mosi/dc are only consumed at s2, so they stop there.
  logic [2:0]    sclk_sync_r;
  logic [2:0]    cs_sync_r;
  logic [1:0]    mosi_sync_r;
  logic [1:0]    dc_sync_r;

  logic [CW-1:0] cnt_r;
  logic [DW-2:0] rx_shift_r;
  logic [DW-1:0] tx_shift_r;
  logic          miso_r;
  logic          tx_taken_r;
  logic [DW-1:0] rx_data_r;
  logic          rx_dc_r;
  logic          rx_valid_r;
  logic          frame_err_r;

  logic          sclk_rise_s;
  logic          sclk_fall_s;
  logic          cs_rise_s;
  logic          cs_fall_s;
  logic          selected_s;
  logic [DW-1:0] rx_word_s;
  logic [DW-1:0] tx_shift_nxt_s;
  logic          tx_load_s;

  assign sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2];
  assign sclk_fall_s = ~sclk_sync_r[1] & sclk_sync_r[2];
  assign cs_rise_s   = cs_sync_r[1] & ~cs_sync_r[2];
  assign cs_fall_s   = ~cs_sync_r[1] & cs_sync_r[2];
  assign selected_s  = ~cs_sync_r[1];
  assign rx_word_s   = {rx_shift_r, mosi_sync_r[1]};

  // Pin synchronisers; cs_n resets to the deselected level so reset release cannot fake a select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_r <= 3'b000;
      cs_sync_r   <= 3'b111;
      mosi_sync_r <= 2'b00;
      dc_sync_r   <= 2'b00;
    end else begin
      sclk_sync_r <= {sclk_sync_r[1:0], bus.sclk};
      cs_sync_r   <= {cs_sync_r[1:0], bus.cs_n};
      mosi_sync_r <= {mosi_sync_r[0], bus.mosi};
      dc_sync_r   <= {dc_sync_r[0], bus.dc};
    end
  end

  // Next response-shifter value. A cs_n rise discards any sclk edge in the same cycle.
  // A word boundary (counter at 0) on an sclk fall reloads instead of shifting.
  always_comb begin
    tx_shift_nxt_s = tx_shift_r;
    tx_load_s      = 1'b0;
    if (cs_rise_s) begin
      tx_shift_nxt_s = tx_shift_r;
      tx_load_s      = 1'b0;
    end else if (cs_fall_s || (selected_s && sclk_fall_s && (cnt_r == CNT_ZERO))) begin
      tx_shift_nxt_s = bus.tx_data;
      tx_load_s      = 1'b1;
    end else if (selected_s && sclk_fall_s) begin
      tx_shift_nxt_s = {tx_shift_r[DW-2:0], 1'b0};
      tx_load_s      = 1'b0;
    end else begin
      tx_shift_nxt_s = tx_shift_r;
      tx_load_s      = 1'b0;
    end
  end

  // Receive datapath, bit counter, response shifter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= CNT_ZERO;
      rx_shift_r  <= {(DW-1){1'b0}};
      tx_shift_r  <= {DW{1'b0}};
      miso_r      <= 1'b0;
      tx_taken_r  <= 1'b0;
      rx_data_r   <= {DW{1'b0}};
      rx_dc_r     <= 1'b0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      tx_shift_r  <= tx_shift_nxt_s;
      tx_taken_r  <= tx_load_s;
      // miso is forced low whenever the synchronised select is inactive (no tri-state).
      miso_r      <= selected_s ? tx_shift_nxt_s[DW-1] : 1'b0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      if (cs_rise_s) begin
        // Partial word is dropped; only a non-zero count means the frame was cut short.
        frame_err_r <= (cnt_r != CNT_ZERO);
        cnt_r       <= CNT_ZERO;
      end else if (selected_s && sclk_rise_s) begin
        rx_shift_r <= rx_word_s[DW-2:0];
        if (cnt_r == CNT_LAST) begin
          rx_data_r  <= rx_word_s;
          rx_dc_r    <= dc_sync_r[1];
          rx_valid_r <= 1'b1;
          cnt_r      <= CNT_ZERO;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign bus.miso      = miso_r;
  assign bus.tx_taken  = tx_taken_r;
  assign bus.rx_data   = rx_data_r;
  assign bus.rx_dc     = rx_dc_r;
  assign bus.rx_valid  = rx_valid_r;
  assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_rx_slave.sv
// tb_spi_rx_slave: self-checking bench for spi_rx_slave. A task-level SPI master
// drives frames; the model is simply the list of words the master completed
// (queue) plus counts derived from frame shape. A monitor compares every cycle.
`timescale 1ns/1ps
module tb_spi_rx_slave;
  localparam int DW = 8;
  localparam int HP = 6;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          dc;
  } rx_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_rx_slave_if #(.DW(DW)) bus ();
  spi_rx_slave #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int taken_cnt = 0;
  int ferr_cnt = 0;
  int valid_cnt = 0;
  int cs_hi_run = 0;
  rx_t exp_q[$];
  rx_t hist[$];
  logic [DW-1:0] mdl_rx;
  logic          mdl_dc;

  logic [DW-1:0] fw[9];
  logic          fdc[9];
  logic [DW-1:0] ftx[10];
  logic [DW-1:0] fgot[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: tally strobes, pop expected words on rx_valid, and hold-check outputs every cycle.
  always @(negedge clk) begin : monitor
    rx_t e;
    if (rst) begin
      mdl_rx    = {DW{1'b0}};
      mdl_dc    = 1'b0;
      cs_hi_run = 0;
    end else begin
      if (bus.tx_taken === 1'b1) taken_cnt++;
      if (bus.frame_err === 1'b1) ferr_cnt++;
      if (bus.rx_valid === 1'b1) begin
        valid_cnt++;
        check("rx_expected_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          mdl_rx = e.d;
          mdl_dc = e.dc;
          hist.push_back(e);
        end
      end
      check("rx_data", 32'(bus.rx_data), 32'(mdl_rx));
      check("rx_dc", 32'(bus.rx_dc), 32'(mdl_dc));
      if (bus.cs_n === 1'b1) cs_hi_run++;
      else cs_hi_run = 0;
      if (cs_hi_run >= 6) check("miso_idle", 32'(bus.miso), 32'd0);
    end
  end

  // Shift nbits of w MSB first; dc only matters on the last bit. Samples miso on each rise.
  task automatic send_bits(input logic [DW-1:0] w, input int nbits, input logic dcv,
                           input logic [DW-1:0] nxt, output logic [DW-1:0] got);
    rx_t e;
    got = {DW{1'b0}};
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = w[DW-1-i];
      bus.dc   = (i == nbits - 1) ? dcv : 1'($urandom_range(0, 1));
      wait_clk(4);
      bus.sclk = 1'b1;
      got[DW-1-i] = bus.miso;
      if (i == DW - 1) begin
        e.d = w;
        e.dc = dcv;
        exp_q.push_back(e);
      end
      wait_clk(HP);
      if (i == DW / 2) bus.tx_data = nxt;
      bus.sclk = 1'b0;
      wait_clk(2);
    end
  endtask

  // One frame: nw full words from fw/fdc, then an optional partial word of tail bits.
  task automatic run_frame(input int nw, input int tail);
    int t0;
    int f0;
    int v0;
    logic [DW-1:0] junk;
    t0 = taken_cnt;
    f0 = ferr_cnt;
    v0 = valid_cnt;
    bus.tx_data = ftx[0];
    wait_clk(2);
    bus.cs_n = 1'b0;
    wait_clk(8);
    for (int w = 0; w < nw; w++) send_bits(fw[w], DW, fdc[w], ftx[w+1], fgot[w]);
    if (tail > 0) send_bits(fw[nw], tail, 1'b0, ftx[nw+1], junk);
    wait_clk(4);
    bus.cs_n = 1'b1;
    wait_clk(10);
    check("tx_taken_count", 32'(taken_cnt - t0), 32'(1 + nw));
    check("frame_err_count", 32'(ferr_cnt - f0), 32'(tail > 0));
    check("rx_valid_count", 32'(valid_cnt - v0), 32'(nw));
    check("rx_queue_drained", 32'(exp_q.size()), 32'd0);
    for (int w = 0; w < nw; w++) check("miso_word", 32'(fgot[w]), 32'(ftx[w]));
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int t0;
    int f0;
    int v0;
    int nw;
    int tail;
    logic [DW-1:0] junk;
    rst = 1'b1;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    bus.dc = 1'b0;
    bus.tx_data = {DW{1'b0}};
    wait_clk(3);
    check("reset_rx_data", 32'(bus.rx_data), 32'd0);
    check("reset_miso", 32'(bus.miso), 32'd0);
    check("reset_strobes", 32'({bus.rx_valid, bus.tx_taken, bus.frame_err, bus.rx_dc}), 32'd0);
    rst = 1'b0;
    wait_clk(4);

    // Single word 0xA5, dc=1.
    hist.delete();
    fw[0] = 8'hA5; fdc[0] = 1'b1; ftx[0] = 8'h96; ftx[1] = 8'h0F;
    run_frame(1, 0);
    check("single_count", 32'(hist.size()), 32'd1);
    if (hist.size() >= 1) begin
      check("single_data", 32'(hist[0].d), 32'hA5);
      check("single_dc", 32'(hist[0].dc), 32'd1);
    end

    // Back-to-back words in one frame.
    hist.delete();
    fw[0] = 8'h2A; fdc[0] = 1'b0;
    fw[1] = 8'h00; fdc[1] = 1'b1;
    fw[2] = 8'h10; fdc[2] = 1'b1;
    ftx[0] = 8'h11; ftx[1] = 8'h22; ftx[2] = 8'h33; ftx[3] = 8'h44;
    run_frame(3, 0);
    check("b2b_count", 32'(hist.size()), 32'd3);
    if (hist.size() >= 3) begin
      check("b2b_data0", 32'(hist[0].d), 32'h2A);
      check("b2b_data1", 32'(hist[1].d), 32'h00);
      check("b2b_data2", 32'(hist[2].d), 32'h10);
      check("b2b_dc_seq", 32'({hist[0].dc, hist[1].dc, hist[2].dc}), 32'b011);
    end

    // Readback: 0x3C then 0xC3 on miso.
    fw[0] = 8'h00; fdc[0] = 1'b0; fw[1] = 8'hFF; fdc[1] = 1'b0;
    ftx[0] = 8'h3C; ftx[1] = 8'hC3; ftx[2] = 8'h00;
    run_frame(2, 0);
    check("readback_word0", 32'(fgot[0]), 32'h3C);
    check("readback_word1", 32'(fgot[1]), 32'hC3);

    // Abort after 5 bits, then a clean 0x81 frame.
    hist.delete();
    fw[0] = 8'hFF; ftx[0] = 8'h55; ftx[1] = 8'hAA;
    run_frame(0, 5);
    check("abort_no_rx", 32'(hist.size()), 32'd0);
    fw[0] = 8'h81; fdc[0] = 1'b0; ftx[0] = 8'h5A; ftx[1] = 8'hA5;
    run_frame(1, 0);
    if (hist.size() >= 1) check("after_abort_data", 32'(hist[0].d), 32'h81);
    check("after_abort_count", 32'(hist.size()), 32'd1);

    // Reset asserted mid-word.
    f0 = ferr_cnt;
    bus.tx_data = 8'hFF;
    wait_clk(2);
    bus.cs_n = 1'b0;
    wait_clk(8);
    send_bits(8'hF0, 3, 1'b1, 8'hFF, junk);
    bus.sclk = 1'b1;
    wait_clk(3);
    rst = 1'b1;
    #1;
    check("midrst_rx_data", 32'(bus.rx_data), 32'd0);
    check("midrst_miso", 32'(bus.miso), 32'd0);
    check("midrst_strobes", 32'({bus.rx_valid, bus.tx_taken, bus.frame_err, bus.rx_dc}), 32'd0);
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(6);
    check("midrst_no_frame_err", 32'(ferr_cnt - f0), 32'd0);
    hist.delete();
    fw[0] = 8'h5A; fdc[0] = 1'b0; ftx[0] = 8'h12; ftx[1] = 8'h34;
    run_frame(1, 0);
    if (hist.size() >= 1) check("after_rst_data", 32'(hist[0].d), 32'h5A);
    check("after_rst_count", 32'(hist.size()), 32'd1);

    // Deselected noise: sclk toggles while cs_n is high.
    t0 = taken_cnt; f0 = ferr_cnt; v0 = valid_cnt;
    for (int i = 0; i < 20; i++) begin
      bus.mosi = 1'($urandom_range(0, 1));
      bus.tx_data = DW'($urandom());
      wait_clk(4);
      bus.sclk = ~bus.sclk;
    end
    bus.sclk = 1'b0;
    wait_clk(6);
    check("noise_tx_taken", 32'(taken_cnt - t0), 32'd0);
    check("noise_rx_valid", 32'(valid_cnt - v0), 32'd0);
    check("noise_frame_err", 32'(ferr_cnt - f0), 32'd0);
    check("noise_miso", 32'(bus.miso), 32'd0);

    // Randomised frames, some ending in a partial word.
    for (int f = 0; f < 20; f++) begin
      nw = $urandom_range(1, 4);
      tail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DW - 1) : 0;
      for (int w = 0; w <= nw; w++) begin
        fw[w] = DW'($urandom());
        fdc[w] = 1'($urandom_range(0, 1));
      end
      for (int w = 0; w <= nw + 1; w++) ftx[w] = DW'($urandom());
      run_frame(nw, tail);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
